// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the sram_bist SRAM self-test controller.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RW_WR,
    S_RD_ONLY,
    S_DRAIN,
    S_FIN
  } state_e;

  typedef logic [2:0] elem_t;

  // E4 is the last read-then-write element; E5 follows as the read-only sweep.
  localparam elem_t ELEM_LAST_RW = 3'd4;

  // Bit e of each table describes march element e (E0..E5).
  localparam logic [7:0] ELEM_UP  = 8'b0010_0111;
  localparam logic [7:0] ELEM_RBG = 8'b0001_0100;
  localparam logic [7:0] ELEM_WBG = 8'b0000_1010;

  function automatic logic elem_up(elem_t e);
    return ELEM_UP[e];
  endfunction

  function automatic logic elem_rbg(elem_t e);
    return ELEM_RBG[e];
  endfunction

  function automatic logic elem_wbg(elem_t e);
    return ELEM_WBG[e];
  endfunction

endpackage

// File: rtl/sram_bist_if.sv
// Single-port synchronous SRAM bus between the BIST initiator and one SRAM instance.
interface sram_bist_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/sram_bist_addr_gen.sv
// Up/down march address counter with load-first, step and end-of-sweep flag.
module sram_bist_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              load_up_i,
  input  logic              step_i,
  input  logic              up_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              is_last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_up_i ? '0 : '1;
    end else if (step_i) begin
      addr_d = up_i ? addr_q + 1'b1 : addr_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr_o    = addr_q;
  assign is_last_o = up_i ? (addr_q == '1) : (addr_q == '0);

endmodule

// File: rtl/sram_bist.sv
// March C- BIST controller for one single-port SRAM with 1-cycle registered read.
// Define SRAM_BIST_STOP_ON_FAIL_EN to abort to FIN on the first miscompare.
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  sram_bist_if.master        mem,
  output logic               busy_o,
  output logic               done_o,
  output logic               fail_o,
  output logic [ADDR_W-1:0]  fail_addr_o,
  output logic [DATA_W-1:0]  fail_rdata_o
);

  state_e            state_q, state_d;
  elem_t             elem_q, elem_d;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              busy_q, busy_d, we_q, we_d, done_q, fail_q;
  logic [DATA_W-1:0] wdata_q, wdata_d, fail_rdata_q;
  logic [ADDR_W-1:0] fail_addr_q, cmp_addr, addr;
  logic              load, load_up, step, is_last, cmp_en, cmp_bg, miscmp;

  sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .load_up_i (load_up),
    .step_i    (step),
    .up_i      (elem_up(elem_q)),
    .addr_o    (addr),
    .is_last_o (is_last)
  );

  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    load     = 1'b0;
    load_up  = 1'b1;
    step     = 1'b0;
    cmp_en   = 1'b0;
    cmp_bg   = 1'b0;
    cmp_addr = addr;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_WR;
        elem_d  = '0;
        load    = 1'b1;
      end
      S_WR: if (is_last) begin
        state_d = S_RD;
        elem_d  = 3'd1;
        load    = 1'b1;
        load_up = elem_up(3'd1);
      end else begin
        step = 1'b1;
      end
      S_RD: state_d = S_RW_WR;
      S_RW_WR: begin
        cmp_en = 1'b1;
        cmp_bg = elem_rbg(elem_q);
        if (!is_last) begin
          step    = 1'b1;
          state_d = S_RD;
        end else begin
          elem_d  = elem_q + 1'b1;
          load    = 1'b1;
          load_up = elem_up(elem_d);
          state_d = (elem_q == ELEM_LAST_RW) ? S_RD_ONLY : S_RD;
        end
      end
      // E5 data arrives one cycle after its address, so compare the pipelined address.
      S_RD_ONLY: begin
        cmp_en   = pend_q;
        cmp_bg   = elem_rbg(elem_q);
        cmp_addr = pend_addr_q;
        if (is_last) state_d = S_DRAIN;
        else         step    = 1'b1;
      end
      S_DRAIN: begin
        cmp_en   = pend_q;
        cmp_bg   = elem_rbg(elem_q);
        cmp_addr = pend_addr_q;
        state_d  = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    miscmp = cmp_en && (mem.mem_rdata != {DATA_W{cmp_bg}});
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    if (miscmp) begin
      state_d = S_FIN;
      load    = 1'b0;
      step    = 1'b0;
    end
`endif

    busy_d  = state_d inside {S_WR, S_RD, S_RW_WR, S_RD_ONLY, S_DRAIN};
    we_d    = state_d inside {S_WR, S_RW_WR};
    wdata_d = we_d ? {DATA_W{elem_wbg(elem_d)}} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      elem_q       <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      pend_q      <= (state_q == S_RD_ONLY);
      pend_addr_q <= addr;
      busy_q      <= busy_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if (state_q == S_IDLE && start_i) begin
        done_q       <= 1'b0;
        fail_q       <= 1'b0;
        fail_addr_q  <= '0;
        fail_rdata_q <= '0;
      end else begin
        if (state_d == S_FIN) done_q <= 1'b1;
        if (miscmp) begin
          fail_q <= 1'b1;
          if (!fail_q) begin
            fail_addr_q  <= cmp_addr;
            fail_rdata_q <= mem.mem_rdata;
          end
        end
      end
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fail_o        = fail_q;
  assign fail_addr_o   = fail_addr_q;
  assign fail_rdata_o  = fail_rdata_q;

endmodule

// File: tb/tb_sram_bist.sv
// Scoreboard bench for sram_bist (ADDR_W=4, N=16) with a fault-injectable behavioural SRAM.
module tb_sram_bist;
  import sram_bist_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_rdata;
  int                fault_mode = 0;

  sram_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  sram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .mem          (mem_if),
    .busy_o       (busy),
    .done_o       (done),
    .fail_o       (fail),
    .fail_addr_o  (fail_addr),
    .fail_rdata_o (fail_rdata)
  );

  always #5 clk = ~clk;

  // mode 1: bit 3 of address 5 stuck at 0; mode 2: writes to address 9 also land in address 8
  logic [DATA_W-1:0] sram [16];
  logic [DATA_W-1:0] rd_val;
  always @(posedge clk) begin
    rd_val = sram[mem_if.mem_addr];
    if (fault_mode == 1 && mem_if.mem_addr == 5) rd_val = rd_val & 8'hF7;
    mem_if.mem_rdata <= rd_val;
    if (mem_if.mem_we) begin
      sram[mem_if.mem_addr] <= mem_if.mem_wdata;
      if (fault_mode == 2 && mem_if.mem_addr == 9) sram[8] <= mem_if.mem_wdata;
    end
  end

  typedef struct {
    string             name;
    int                busy_cyc;
    int                we_cyc;
    logic              fail;
    logic [ADDR_W-1:0] faddr;
    logic [DATA_W-1:0] frdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input string name, input int bc, input int wc, input logic f,
                          input int fa, input int fr);
    exp_t e;
    e.name = name; e.busy_cyc = bc; e.we_cyc = wc;
    e.fail = f; e.faddr = ADDR_W'(fa); e.frdata = DATA_W'(fr);
    sb_q.push_back(e);
  endtask

  // Monitor: measures each run and checks it against the queued expectation when done rises.
  initial begin
    int   busy_cnt;
    int   we_cnt;
    logic done_prev;
    exp_t e;
    busy_cnt = 0; we_cnt = 0; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
        we_cnt   = 0;
      end else begin
        if (busy) busy_cnt++;
        if (mem_if.mem_we) we_cnt++;
        if (done && !done_prev) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_busy_cycles"}, busy_cnt, e.busy_cyc);
            check({e.name, "_we_cycles"}, we_cnt, e.we_cyc);
            check({e.name, "_busy_at_done"}, int'(busy), 0);
            check({e.name, "_fail"}, int'(fail), int'(e.fail));
            check({e.name, "_fail_addr"}, int'(fail_addr), int'(e.faddr));
            check({e.name, "_fail_rdata"}, int'(fail_rdata), int'(e.frdata));
          end
          busy_cnt = 0;
          we_cnt   = 0;
        end
      end
      done_prev = done;
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
    check({name, "_fail"}, int'(fail), 0);
    check({name, "_fail_addr"}, int'(fail_addr), 0);
    check({name, "_fail_rdata"}, int'(fail_rdata), 0);
    check({name, "_mem_we"}, int'(mem_if.mem_we), 0);
    check({name, "_mem_addr"}, int'(mem_if.mem_addr), 0);
    check({name, "_mem_wdata"}, int'(mem_if.mem_wdata), 0);
  endtask

  task automatic do_start(input string name);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({name, "_start_busy"}, int'(busy), 1);
    check({name, "_start_we"}, int'(mem_if.mem_we), 1);
    check({name, "_start_addr"}, int'(mem_if.mem_addr), 0);
    check({name, "_start_wdata"}, int'(mem_if.mem_wdata), 0);
    check({name, "_start_done_clr"}, int'(done), 0);
    check({name, "_start_fail_clr"}, int'(fail), 0);
  endtask

  task automatic wait_empty(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    check({name, "_pending_at_timeout"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d expected completion", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;

    fault_mode = 0;
    push_exp("clean", 161, 80, 1'b0, 0, 0);
    do_start("clean");
    wait_empty("clean");
    repeat (3) @(posedge clk);
    #1 check("clean_done_sticky", int'(done), 1);

    fault_mode = 1;
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    push_exp("stuck", 60, 38, 1'b1, 5, 8'hF7);
`else
    push_exp("stuck", 161, 80, 1'b1, 5, 8'hF7);
`endif
    do_start("stuck");
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
`ifndef SRAM_BIST_STOP_ON_FAIL_EN
    repeat (48) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("busy_start_keeps_fail", int'(fail), 1);
    check("busy_start_keeps_fail_addr", int'(fail_addr), 5);
    check("busy_start_keeps_busy", int'(busy), 1);
`endif
    wait_empty("stuck");

    fault_mode = 2;
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    push_exp("coupling", 96, 56, 1'b1, 8, 8'hFF);
`else
    push_exp("coupling", 161, 80, 1'b1, 8, 8'hFF);
`endif
    do_start("coupling");
    wait_empty("coupling");

    fault_mode = 0;
    do_start("abort");
    repeat (70) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrun_rst");
    rst = 1'b0;
    push_exp("after_rst", 161, 80, 1'b0, 0, 0);
    do_start("after_rst");
    wait_empty("after_rst");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_bist.md
Name: sram_bist

Overview:
- March C- built-in self-test controller.
- Acts as the initiator on the single-port synchronous SRAM interface: write enable, address and write data out; registered read data back, with 1-cycle read latency.
- Sits between a test-mode controller (start/done/fail) and one SRAM instance.
- Checks every location with an all-zeros / all-ones background and reports the first failing address.

Parameters:
- ADDR_W, 10, SRAM address width; depth N = 2**ADDR_W.
- DATA_W, 8, SRAM data width; background 0 = all zeros, background 1 = all ones.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a test; sampled only in IDLE.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM registered read data; holds mem[addr presented the previous cycle].
- busy  out  1  test in progress.
- done  out  1  sticky: test finished; cleared by the next accepted start.
- fail  out  1  sticky: at least one miscompare; cleared by the next accepted start.
- fail_addr  out  ADDR_W  address of the first miscompare.
- fail_rdata  out  DATA_W  data read at the first miscompare.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE.
- All outputs are registered.
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- March sequence, run in this order:
  - E0 up (w0)
  - E1 up (r0, w1)
  - E2 up (r1, w0)
  - E3 down (r0, w1)
  - E4 down (r1, w0)
  - E5 up (r0)
- Up means address 0 to N-1; down means N-1 to 0.
- States: IDLE, WR, RD, RW_WR, RD_ONLY, DRAIN, FIN.
- IDLE: start=1 at an edge moves to WR and clears done/fail/fail_addr/fail_rdata.
- Accepted start:
  - busy=1 from the next cycle.
  - mem_addr=0, mem_we=1, mem_wdata=0.
- WR (E0): one write per cycle. After address N-1 go to RD with element E1 at address 0.
- RD: drive mem_we=0 at the current address, then go to RW_WR.
- RW_WR:
  - Same address.
  - mem_we=1, mem_wdata = element write background.
  - Compare mem_rdata against the element read background.
  - Step the address up or down.
  - If the address is not at the element's last address, return to RD.
  - Otherwise advance the element; E4 leads to RD_ONLY at address 0.
- RD_ONLY (E5): one read per cycle, mem_we=0. mem_rdata is compared in the following cycle (pipelined). After address N-1 go to DRAIN.
- DRAIN: final compare; then go to FIN.
- FIN: busy=0, done=1, then back to IDLE.
- Total busy cycles = N + 8N + N + 1 = 10N+1.
- Miscompare:
  - fail is set.
  - fail_addr and fail_rdata are captured only if fail was previously 0 (first failure wins).
  - The compare address is the address of the read being checked, so E5 uses a pipelined copy.
- start while busy: ignored.
- start in the same cycle that done would be observed: ignored until IDLE.
- rst mid-run: next cycle IDLE with all outputs 0. SRAM contents are undefined afterwards; no recovery write.
- Address counter wraps only under FSM control; no out-of-range address is ever driven.

Optional Feature:
- SRAM_BIST_STOP_ON_FAIL_EN defined: on the first miscompare the FSM goes directly to FIN on the next edge.
  - mem_we is forced to 0 that cycle.
  - busy drops; done=1, fail=1.
- Undefined: the full march always completes (10N+1 cycles) regardless of failures.

Decomposition:
- Package sram_bist_pkg:
  - FSM state enum.
  - Element index type (3 bits).
  - Localparams for per-element direction, read background and write background (lookup functions indexed by element).
- Sub-module sram_bist_addr_gen:
  - Up/down ADDR_W counter with load-first, step, and is_last flag.
  - Instantiated once.

Test Plan (ADDR_W=4, DATA_W=8, N=16, behavioural SRAM model with 1-cycle read):
- Fault-free model, pulse start -> busy high exactly 161 cycles, then done=1, fail=0; mem_we asserted exactly 16+64 = 80 cycles.
- Bit 3 stuck-at-0 at address 5 -> fail=1, fail_addr=5, fail_rdata=0xF7 (first seen in E2 r1); done after 161 cycles.
- Write to address 9 also flips address 8 (coupling fault) -> fail=1, fail_addr=8 (detected at the E3 downward r0); confirms E3/E4 address order 15..0.
- start pulsed at cycle 50 of a run -> ignored; run length is still 161; done/fail not cleared.
- rst asserted at cycle 70 -> all outputs 0 the next cycle. A new start then gives a full 161-cycle clean run.
- With SRAM_BIST_STOP_ON_FAIL_EN and the stuck-at fault at address 5 -> done=1 and fail_addr=5 on the cycle after the E2 compare of address 5; no further mem_we after the fail.
